// File: rtl/data_ram_confreg.sv
// CPU data-port responder: byte-writable word RAM plus a small peripheral register window
// (LED, switches, 7-seg number, free-running timer), with a fixed one-cycle read latency.
module data_ram_confreg #(
  parameter int unsigned ADDR_W    = 14,
  parameter logic [31:0] CONF_BASE = 32'hBFAF_0000,
  parameter logic [31:0] CONF_MASK = 32'hFFFF_0000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] data_ram_addr,
  input  logic [3:0]  data_ram_we,
  input  logic [31:0] data_ram_din,
  output logic [31:0] data_ram_data,
  input  logic [7:0]  switch,
  output logic [15:0] led,
  output logic [31:0] num_data
);

  localparam int unsigned DEPTH   = 1 << ADDR_W;
  localparam logic [15:0] OFF_LED = 16'hF000;
  localparam logic [15:0] OFF_SW  = 16'hF004;
  localparam logic [15:0] OFF_NUM = 16'hF010;
  localparam logic [15:0] OFF_TMR = 16'hE000;

  logic [31:0] ram_q [DEPTH];

  logic [31:0] data_q, data_d;
  logic [15:0] led_q, led_d;
  logic [31:0] num_q, num_d;
  logic [31:0] timer_q, timer_d;
  logic [7:0]  sw_s1_q, sw_s1_d;
  logic [7:0]  sw_s2_q, sw_s2_d;

  logic              conf_hit_c;
  logic [15:0]       offset_c;
  logic [ADDR_W-1:0] ram_idx_c;
  logic [31:0]       ram_rdata_c;
  logic [31:0]       ram_wdata_c;
  logic              ram_wen_c;
  logic              conf_wen_c;
  logic [31:0]       conf_rdata_c;

  assign conf_hit_c  = (data_ram_addr & CONF_MASK) == CONF_BASE;
  assign offset_c    = data_ram_addr[15:0];
  assign ram_idx_c   = data_ram_addr[ADDR_W+1:2];
  assign ram_rdata_c = ram_q[ram_idx_c];
  assign ram_wen_c   = resetn && !conf_hit_c && (data_ram_we != 4'h0);
  assign conf_wen_c  = resetn && conf_hit_c && (data_ram_we == 4'hF);

  // Merge enabled bytes of din over the current word so RAM sees a single full-word write.
  always_comb begin
    ram_wdata_c = ram_rdata_c;
    for (int i = 0; i < 4; i++) begin
      if (data_ram_we[i]) ram_wdata_c[8*i +: 8] = data_ram_din[8*i +: 8];
    end
  end

  // Peripheral read mux and next-state for all registered state.
  always_comb begin
    conf_rdata_c = 32'h0;
    led_d        = led_q;
    num_d        = num_q;
    timer_d      = timer_q + 32'd1;
    sw_s1_d      = switch;
    sw_s2_d      = sw_s1_q;

    case (offset_c)
      OFF_LED: conf_rdata_c = {16'h0, led_q};
      OFF_SW:  conf_rdata_c = {24'h0, sw_s2_q};
      OFF_NUM: conf_rdata_c = num_q;
      OFF_TMR: conf_rdata_c = timer_q;
      default: conf_rdata_c = 32'h0;
    endcase

    if (conf_wen_c) begin
      case (offset_c)
        OFF_LED: led_d   = data_ram_din[15:0];
        OFF_NUM: num_d   = data_ram_din;
        OFF_TMR: timer_d = data_ram_din;
        default: ;
      endcase
    end

    data_d = conf_hit_c ? conf_rdata_c : ram_rdata_c;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      data_q  <= 32'h0;
      led_q   <= 16'h0;
      num_q   <= 32'h0;
      timer_q <= 32'h0;
      sw_s1_q <= 8'h0;
      sw_s2_q <= 8'h0;
    end else begin
      data_q  <= data_d;
      led_q   <= led_d;
      num_q   <= num_d;
      timer_q <= timer_d;
      sw_s1_q <= sw_s1_d;
      sw_s2_q <= sw_s2_d;
    end
  end

  // RAM contents survive reset; writes are gated off while resetn is low.
  always_ff @(posedge clock) begin
    if (ram_wen_c) ram_q[ram_idx_c] <= ram_wdata_c;
  end

  assign data_ram_data = data_q;
  assign led           = led_q;
  assign num_data      = num_q;

endmodule
